// File: rtl/shift_chain_monitor.sv
// Watches a clock-divided shift chain, waits for each step to settle, checks the shift
// relation, counts steps and flags faults. Define SHIFT_MON_WATCHDOG_EN for the stall watchdog.
module shift_chain_monitor #(
    parameter int TAPS          = 3,
    parameter int SETTLE_CYCLES = 4,
    parameter int COUNT_W       = 8,
    parameter int WDOG_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TAPS-1:0]         tap_in,
    input  logic                    clr_fault,
    output logic [TAPS-1:0]         taps_q,
    output logic                    step_pulse,
    output logic [COUNT_W-1:0]      step_count,
    output logic                    fault,
    output logic [$clog2(TAPS)-1:0] fault_tap,
    output logic                    busy,
    output logic                    stall
);
    localparam int FT_W  = $clog2(TAPS);
    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRACK, SETTLE, FAULT} state_t;

    state_t             state_q, state_d;
    logic [TAPS-1:0]    s1_q, sync_q, prev_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_cur;
    logic               stable;
    logic [TAPS-1:0]    ref_q, ref_d;
    logic               step_q, step_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               fault_q, fault_d;
    logic [FT_W-1:0]    ftap_q, ftap_d;
    logic               shift_ok;
    logic [FT_W-1:0]    bad_k;

    // prev_q holds sync one cycle back so changes can restart the settle count
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= tap_in;
            sync_q <= s1_q;
            prev_q <= sync_q;
        end
    end

    always_comb begin
        if (sync_q != prev_q) begin
            cnt_cur = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_cur = cnt_q;
        end else begin
            cnt_cur = cnt_q + 1'b1;
        end
    end

    assign stable = (cnt_cur == CNT_MAX);

    // Scan downwards so the lowest failing tap is the one left in bad_k
    always_comb begin
        shift_ok = 1'b1;
        bad_k    = '0;
        for (int k = TAPS - 1; k >= 1; k--) begin
            if (sync_q[k] != ref_q[k-1]) begin
                shift_ok = 1'b0;
                bad_k    = FT_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_cur;
        ref_d   = ref_q;
        step_d  = 1'b0;
        count_d = count_q;
        fault_d = fault_q;
        ftap_d  = ftap_q;
        unique case (state_q)
            IDLE: begin
                if (stable) begin
                    ref_d   = sync_q;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (sync_q != ref_q) begin
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (stable) begin
                    if (sync_q == ref_q) begin
                        state_d = TRACK;
                    end else if (shift_ok) begin
                        ref_d   = sync_q;
                        step_d  = 1'b1;
                        state_d = TRACK;
                        if (!(&count_q)) begin
                            count_d = count_q + 1'b1;
                        end
                    end else begin
                        ref_d   = sync_q;
                        fault_d = 1'b1;
                        ftap_d  = bad_k;
                        state_d = FAULT;
                    end
                end
            end
            FAULT: begin
                if (clr_fault) begin
                    fault_d = 1'b0;
                    ftap_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ref_q   <= '0;
            step_q  <= 1'b0;
            count_q <= '0;
            fault_q <= 1'b0;
            ftap_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            step_q  <= step_d;
            count_q <= count_d;
            fault_q <= fault_d;
            ftap_q  <= ftap_d;
        end
    end

    assign taps_q     = ref_q;
    assign step_pulse = step_q;
    assign step_count = count_q;
    assign fault      = fault_q;
    assign fault_tap  = ftap_q;
    assign busy       = (state_q == SETTLE);

`ifdef SHIFT_MON_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              stall_q, stall_d;

    always_comb begin
        wdog_d  = wdog_q;
        stall_d = stall_q;
        if (step_d || state_d == IDLE) begin
            wdog_d = '0;
        end else if (state_q == TRACK || state_q == SETTLE) begin
            if (&wdog_q) begin
                stall_d = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
        if (step_d || (state_q == FAULT && clr_fault)) begin
            stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q  <= '0;
            stall_q <= 1'b0;
        end else begin
            wdog_q  <= wdog_d;
            stall_q <= stall_d;
        end
    end

    assign stall = stall_q;
`else
    assign stall = |{WDOG_W{1'b0}};
`endif

endmodule
